// File: rtl/dn_port_arbiter.sv
// Shares the core download/NVRAM port between the ioctl loader and the hiscore engine.
// One transaction at a time; writes take 3 cycles IDLE-to-IDLE, reads 3+RD_LAT; one-cycle ack.
module dn_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              paused,
  input  logic              ld_lock,
  input  logic              ld_req,
  input  logic              hs_req,
  input  logic              ld_we,
  input  logic              hs_we,
  input  logic              ld_nv,
  input  logic              hs_nv,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] hs_wdata,
  output logic              ld_ack,
  output logic              hs_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_wr,
  output logic              dn_nvram_wr,
  output logic              dn_nvram,
  input  logic [DATA_W-1:0] dn_din,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t state, state_nx;

  logic              grant_ld, grant_hs, hs_elig;
  logic              sel_we, sel_nv;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              t_we, t_ld, last_ld;
  logic [2:0]        cnt;

  always_comb begin
    grant_ld  = 1'b0;
    grant_hs  = 1'b0;
    hs_elig   = hs_req && paused && !ld_lock;
    if (ld_req && hs_elig) begin
      // last_ld resets to 0 ("hiscore went last") so the loader wins the first tie
      grant_ld = !last_ld;
      grant_hs = last_ld;
    end else begin
      grant_ld = ld_req;
      grant_hs = hs_elig;
    end
    sel_we    = grant_ld ? ld_we    : hs_we;
    sel_nv    = grant_ld ? ld_nv    : hs_nv;
    sel_addr  = grant_ld ? ld_addr  : hs_addr;
    sel_wdata = grant_ld ? ld_wdata : hs_wdata;

    state_nx = state;
    case (state)
      S_IDLE:  if (grant_ld || grant_hs) state_nx = S_ISSUE;
      S_ISSUE: state_nx = t_we ? S_ACK : S_WAIT;
      S_WAIT:  if (cnt == 3'd1) state_nx = S_ACK;
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // dn_addr/dn_data/dn_nvram double as the transaction register, so they
  // hold the last transaction's values while idle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      t_we        <= 1'b0;
      t_ld        <= 1'b0;
      last_ld     <= 1'b0;
      cnt         <= 3'd0;
      ld_ack      <= 1'b0;
      hs_ack      <= 1'b0;
      rdata       <= '0;
      dn_addr     <= '0;
      dn_data     <= '0;
      dn_wr       <= 1'b0;
      dn_nvram_wr <= 1'b0;
      dn_nvram    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dn_wr       <= 1'b0;
      dn_nvram_wr <= 1'b0;
      ld_ack      <= 1'b0;
      hs_ack      <= 1'b0;
      busy        <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (grant_ld || grant_hs) begin
            t_ld        <= grant_ld;
            t_we        <= sel_we;
            dn_addr     <= sel_addr;
            dn_data     <= sel_wdata;
            dn_nvram    <= sel_nv;
            dn_wr       <= sel_we && !sel_nv;
            dn_nvram_wr <= sel_we && sel_nv;
          end
        end
        S_ISSUE: begin
          if (t_we) begin
            ld_ack <= t_ld;
            hs_ack <= !t_ld;
          end else begin
            cnt <= LAT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rdata  <= dn_din;
            ld_ack <= t_ld;
            hs_ack <= !t_ld;
          end
        end
        S_ACK:   last_ld <= t_ld;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Directed checks of dn_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=4, shared inputs.
module tb_dn_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n, paused, ld_lock;
  logic        ld_req, hs_req, ld_we, hs_we, ld_nv, hs_nv;
  logic [15:0] ld_addr, hs_addr;
  logic [7:0]  ld_wdata, hs_wdata, dn_din;

  logic        ld_ack1, hs_ack1, dn_wr1, dn_nvram_wr1, dn_nvram1, busy1;
  logic [7:0]  rdata1, dn_data1;
  logic [15:0] dn_addr1;
  logic        ld_ack4, hs_ack4, dn_wr4, dn_nvram_wr4, dn_nvram4, busy4;
  logic [7:0]  rdata4, dn_data4;
  logic [15:0] dn_addr4;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  dn_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .paused(paused), .ld_lock(ld_lock),
    .ld_req(ld_req), .hs_req(hs_req), .ld_we(ld_we), .hs_we(hs_we),
    .ld_nv(ld_nv), .hs_nv(hs_nv), .ld_addr(ld_addr), .hs_addr(hs_addr),
    .ld_wdata(ld_wdata), .hs_wdata(hs_wdata), .ld_ack(ld_ack1), .hs_ack(hs_ack1),
    .rdata(rdata1), .dn_addr(dn_addr1), .dn_data(dn_data1), .dn_wr(dn_wr1),
    .dn_nvram_wr(dn_nvram_wr1), .dn_nvram(dn_nvram1), .dn_din(dn_din), .busy(busy1)
  );

  dn_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(4)) u4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .paused(paused), .ld_lock(ld_lock),
    .ld_req(ld_req), .hs_req(hs_req), .ld_we(ld_we), .hs_we(hs_we),
    .ld_nv(ld_nv), .hs_nv(hs_nv), .ld_addr(ld_addr), .hs_addr(hs_addr),
    .ld_wdata(ld_wdata), .hs_wdata(hs_wdata), .ld_ack(ld_ack4), .hs_ack(hs_ack4),
    .rdata(rdata4), .dn_addr(dn_addr4), .dn_data(dn_data4), .dn_wr(dn_wr4),
    .dn_nvram_wr(dn_nvram_wr4), .dn_nvram(dn_nvram4), .dn_din(dn_din), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; paused = 1'b0; ld_lock = 1'b0;
    ld_req = 1'b0; hs_req = 1'b0; ld_we = 1'b0; hs_we = 1'b0;
    ld_nv = 1'b0; hs_nv = 1'b0; ld_addr = '0; hs_addr = '0;
    ld_wdata = '0; hs_wdata = '0; dn_din = '0;
    tick(); tick(); tick();

    chk("rst_busy",  {31'd0, busy1}, 32'd0);
    chk("rst_strb",  {30'd0, dn_wr1, dn_nvram_wr1}, 32'd0);
    chk("rst_acks",  {30'd0, ld_ack1, hs_ack1}, 32'd0);
    chk("rst_addr",  {16'd0, dn_addr1}, 32'd0);
    chk("rst_data",  {16'd0, dn_data1, rdata1}, 32'd0);

    // loader ROM write
    reset_n = 1'b1;
    tick();
    ld_req = 1'b1; ld_we = 1'b1; ld_nv = 1'b0; ld_addr = 16'h1234; ld_wdata = 8'hA5;
    tick();
    chk("wr_dn_wr",   {31'd0, dn_wr1}, 32'd1);
    chk("wr_nvwr",    {31'd0, dn_nvram_wr1}, 32'd0);
    chk("wr_addr",    {16'd0, dn_addr1}, 32'h1234);
    chk("wr_data",    {24'd0, dn_data1}, 32'hA5);
    chk("wr_busy",    {31'd0, busy1}, 32'd1);
    chk("wr_noack",   {31'd0, ld_ack1}, 32'd0);
    tick();
    chk("wr_ack",     {30'd0, ld_ack1, hs_ack1}, 32'b10);
    chk("wr_strb_off",{31'd0, dn_wr1}, 32'd0);
    ld_req = 1'b0;
    tick();
    chk("wr_idle",    {30'd0, busy1, ld_ack1}, 32'd0);
    chk("wr_hold",    {16'd0, dn_addr1}, 32'h1234);

    // hiscore NVRAM read, RD_LAT=1
    paused = 1'b1; dn_din = 8'h3C;
    hs_req = 1'b1; hs_we = 1'b0; hs_nv = 1'b1; hs_addr = 16'h0042; hs_wdata = 8'h99;
    tick();
    chk("rd_nvram",   {31'd0, dn_nvram1}, 32'd1);
    chk("rd_addr",    {16'd0, dn_addr1}, 32'h0042);
    chk("rd_strb1",   {30'd0, dn_wr1, dn_nvram_wr1}, 32'd0);
    tick();
    chk("rd_wait",    {30'd0, ld_ack1, hs_ack1}, 32'd0);
    chk("rd_strb2",   {30'd0, dn_wr1, dn_nvram_wr1}, 32'd0);
    tick();
    chk("rd_ack",     {30'd0, ld_ack1, hs_ack1}, 32'b01);
    chk("rd_rdata",   {24'd0, rdata1}, 32'h3C);
    hs_req = 1'b0;
    tick();
    chk("rd_rdata_hold", {24'd0, rdata1}, 32'h3C);

    // hiscore gated while not paused
    do_reset();
    paused = 1'b0;
    hs_req = 1'b1; hs_we = 1'b1; hs_nv = 1'b1; hs_addr = 16'h0077; hs_wdata = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("gate_idle", {30'd0, busy1, hs_ack1}, 32'd0);
    end
    paused = 1'b1;
    tick();
    chk("gate_nvwr",  {30'd0, dn_wr1, dn_nvram_wr1}, 32'b01);
    tick();
    chk("gate_ack",   {30'd0, ld_ack1, hs_ack1}, 32'b01);
    hs_req = 1'b0;

    // round-robin with both held, paused=1, no lock
    ld_req = 1'b1; ld_we = 1'b1; ld_nv = 1'b0; ld_addr = 16'h1111; ld_wdata = 8'h11;
    hs_req = 1'b1; hs_we = 1'b1; hs_nv = 1'b1; hs_addr = 16'h2222; hs_wdata = 8'h22;
    paused = 1'b1; ld_lock = 1'b0;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rr_ack", {30'd0, ld_ack1, hs_ack1},
          {30'd0, (i % 6) == 2, (i % 6) == 5});
    end

    // lock: loader only, then hiscore after unlock
    ld_lock = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("lock_ack", {30'd0, ld_ack1, hs_ack1}, {30'd0, (i % 3) == 2, 1'b0});
    end
    ld_lock = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("unlock_ack", {30'd0, ld_ack1, hs_ack1}, {30'd0, i == 5, i == 2});
    end
    ld_req = 1'b0; hs_req = 1'b0;

    // reset mid-read on the RD_LAT=4 instance
    do_reset();
    tick();
    dn_din = 8'h7E;
    ld_req = 1'b1; ld_we = 1'b0; ld_nv = 1'b0; ld_addr = 16'h5555;
    tick();
    tick();
    tick();
    chk("mid_busy",   {30'd0, busy4, ld_ack4}, 32'b10);
    hs_req = 1'b1; hs_we = 1'b1; hs_nv = 1'b1; paused = 1'b1;
    reset_n = 1'b0;
    tick();
    chk("mr_busy",    {31'd0, busy4}, 32'd0);
    chk("mr_acks",    {30'd0, ld_ack4, hs_ack4}, 32'd0);
    chk("mr_addr",    {16'd0, dn_addr4}, 32'd0);
    chk("mr_misc",    {29'd0, dn_nvram4, dn_wr4, dn_nvram_wr4}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("mr_regrant", {16'd0, dn_addr4}, 32'h5555);
    chk("mr_nostrb",  {30'd0, dn_wr4, dn_nvram_wr4}, 32'd0);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("mr_ack", {30'd0, ld_ack4, hs_ack4}, {30'd0, i == 6, 1'b0});
    end
    chk("mr_rdata",   {24'd0, rdata4}, 32'h7E);
    ld_req = 1'b0; hs_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dn_port_arbiter.md
# dn_port_arbiter

Sequences and shares the game core's single download/NVRAM port (dn_addr, dn_data, dn_wr, dn_nvram_wr, dn_nvram, dn_din) between two requesters: the ioctl loader (ROM download and NVRAM dump/restore) and the hiscore engine. It sits in the emu top level between hps_io/nvram and the defender core, replacing the ad-hoc address mux. It grants one transaction at a time, runs each transaction for a fixed number of cycles, and returns a one-cycle acknowledge. Hiscore accesses are granted only while the CPU is paused.

## Interface
- ADDR_W, 16, address width of the core port.
- DATA_W, 8, data width.
- RD_LAT, 1, core read latency in clk_sys cycles from address presented to dn_din valid (1..7).

- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- paused  in  1  CPU pause acknowledge; gates hiscore grants.
- ld_lock  in  1  loader burst lock (ioctl_download active); forces loader priority.
- ld_req / hs_req  in  1  request, level, held until ack.
- ld_we / hs_we  in  1  1=write, 0=read.
- ld_nv / hs_nv  in  1  target NVRAM space (1) or ROM space (0).
- ld_addr / hs_addr  in  ADDR_W  address.
- ld_wdata / hs_wdata  in  DATA_W  write data.
- ld_ack / hs_ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid in the ack cycle, held until next read completes.
- dn_addr  out  ADDR_W  core port address.
- dn_data  out  DATA_W  core port write data.
- dn_wr  out  1  ROM-space write strobe.
- dn_nvram_wr  out  1  NVRAM-space write strobe.
- dn_nvram  out  1  NVRAM space select.
- dn_din  in  DATA_W  core port read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: evaluate eligible requests. Loader is eligible when ld_req=1. Hiscore is eligible when hs_req=1 and paused=1.
  - If ld_lock=1, only the loader can be granted.
  - Otherwise both eligible: round-robin. Grant the requester not granted last; the last-owner bit resets to "hiscore", so the loader wins first.
  - On grant, register we, nv, addr and wdata from the winner into the transaction register, then go to ISSUE.
- ISSUE (1 cycle): dn_addr, dn_data and dn_nvram are driven from the transaction register. Write: assert dn_nvram_wr if nv=1, else dn_wr, for exactly this cycle, then go to ACK. Read: load wait counter with RD_LAT, then go to WAIT.
- WAIT: decrement counter. When counter==1, capture dn_din into rdata and go to ACK.
- ACK (1 cycle): pulse the granted requester's ack, update the last-owner bit, then go to IDLE.
- dn_addr, dn_data and dn_nvram hold their last transaction values in IDLE.
- Request fields are sampled only at grant. Deasserting req or changing fields after grant does not abort; ack still pulses.
- A requester that keeps req high after ack is re-evaluated in the next IDLE cycle as a new request.
- ld_lock or paused changing mid-transaction has no effect until the next IDLE.
- Reset (reset_n=0 at an edge): go to IDLE and abandon any transaction with no ack. All outputs become 0, last-owner becomes hiscore, counter clears.

## Timing
- Request seen in IDLE at cycle n.
  - Write: ISSUE at n+1 with strobe high, ACK at n+2, IDLE at n+3. Back-to-back writes accepted every 3 cycles.
  - Read: ISSUE at n+1, WAIT at n+2..n+1+RD_LAT, ACK at n+2+RD_LAT with rdata valid.
- All outputs are registered. Strobes never overlap, and at most one ack is high per cycle.
- busy rises the cycle after the request is sampled and falls in the cycle after ACK.

## Test plan
- Loader write: ld_req=1, we=1, nv=0, addr=16'h1234, wdata=8'hA5 -> dn_wr=1 with dn_addr=1234, dn_data=A5 exactly 1 cycle later; ld_ack 2 cycles after the request; dn_nvram_wr stays 0.
- Hiscore read, paused=1, RD_LAT=1, nv=1, addr=16'h0042, dn_din=8'h3C -> dn_nvram=1, hs_ack 3 cycles after the request, rdata=3C; no write strobe.
- Hiscore gating: hs_req=1 with paused=0 for 20 cycles -> no grant, busy=0. Raise paused -> hs_ack follows.
- Round-robin: both requesters held high with we=1, ld_lock=0, paused=1 -> grants alternate loader, hiscore, loader, …; one ack per 3 cycles.
- Lock: both requesters held high, ld_lock=1 -> only loader acks; hiscore is starved until ld_lock=0.
- Reset mid-read, RD_LAT=4: assert reset_n=0 during WAIT -> no ack, next cycle all outputs 0 and busy=0. After release, a pending ld_req is granted first.
